// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - LC-3b 5-stage pipeline sequencer (optional PIPE_CTRL_PERF_EN perf counters)
module pipe_ctrl #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_resp,
  input  logic              dcache_req,
  input  logic              dcache_resp,
  input  logic              dep_stall,
  input  logic              de_is_ctrl,
  input  logic              mem_br_resolve,
  input  logic              mem_br_taken,
  input  logic              mem_is_trap,
  output logic              fetch_en,
  output logic              load_pc,
  output logic [1:0]        pc_mux_sel,
  output logic              load_de,
  output logic              load_ex,
  output logic              load_mem,
  output logic              load_wb,
  output logic              valid_de,
  output logic              valid_ex,
  output logic              valid_mem,
  output logic              valid_wb,
  output logic              br_wait
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_retired,
  output logic [PERF_W-1:0] perf_mstall,
  output logic [PERF_W-1:0] perf_brwait
`endif
);

  typedef enum logic {RUN = 1'b0, BR_WAIT = 1'b1} state_t;

  state_t state;
  state_t next_state;

  logic mstall;
  logic ctrl_de;
  logic resolve;

  // A dcache miss freezes everything up to MEM; a control op in DE freezes fetch.
  assign mstall  = valid_mem & dcache_req & ~dcache_resp;
  assign ctrl_de = valid_de & de_is_ctrl;
  assign resolve = valid_mem & mem_br_resolve & ~mstall;
  assign br_wait = rst_n & (state == BR_WAIT);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= next_state;
  end

  // Load enables, fetch/PC control and next state; all forced low during reset.
  always_comb begin
    next_state = state;
    fetch_en   = 1'b0;
    load_pc    = 1'b0;
    pc_mux_sel = 2'b00;
    load_de    = 1'b0;
    load_ex    = 1'b0;
    load_mem   = 1'b0;
    load_wb    = 1'b0;
    if (rst_n) begin
      load_wb  = 1'b1;
      load_mem = ~mstall;
      load_ex  = ~mstall;
      load_de  = ~mstall & ~dep_stall;
      case (state)
        RUN: begin
          // The word fetched beside a control op is dropped; PC already holds fall-through.
          fetch_en = ~ctrl_de;
          load_pc  = load_de & icache_resp & ~ctrl_de;
          if (ctrl_de && load_de) next_state = BR_WAIT;
        end
        BR_WAIT: begin
          if (resolve) begin
            next_state = RUN;
            if (mem_is_trap) begin
              load_pc    = 1'b1;
              pc_mux_sel = 2'b10;
            end else if (mem_br_taken) begin
              load_pc    = 1'b1;
              pc_mux_sel = 2'b01;
            end
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  // Stage valid bits: each holds when its latch does not load; stalls insert bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_de  <= 1'b0;
      valid_ex  <= 1'b0;
      valid_mem <= 1'b0;
      valid_wb  <= 1'b0;
    end else begin
      valid_wb <= valid_mem & ~mstall;
      if (load_mem) valid_mem <= valid_ex;
      if (load_ex)  valid_ex  <= valid_de & ~dep_stall;
      if (load_de)  valid_de  <= (state == RUN) & ~ctrl_de & icache_resp;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_retired <= '0;
      perf_mstall  <= '0;
      perf_brwait  <= '0;
    end else begin
      if (valid_wb && (perf_retired != '1))
        perf_retired <= perf_retired + PERF_W'(1);
      if (mstall && (perf_mstall != '1))
        perf_mstall <= perf_mstall + PERF_W'(1);
      if ((state == BR_WAIT) && (perf_brwait != '1))
        perf_brwait <= perf_brwait + PERF_W'(1);
    end
  end
`else
  logic [PERF_W-1:0] perf_unused;
  assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int PERF_W = 16;

  logic clk = 1'b0;
  logic rst_n, icache_resp, dcache_req, dcache_resp, dep_stall, de_is_ctrl;
  logic mem_br_resolve, mem_br_taken, mem_is_trap;
  logic fetch_en, load_pc, load_de, load_ex, load_mem, load_wb;
  logic [1:0] pc_mux_sel;
  logic valid_de, valid_ex, valid_mem, valid_wb, br_wait;
`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_retired, perf_mstall, perf_brwait;
`endif

  pipe_ctrl #(.PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n), .icache_resp(icache_resp), .dcache_req(dcache_req),
    .dcache_resp(dcache_resp), .dep_stall(dep_stall), .de_is_ctrl(de_is_ctrl),
    .mem_br_resolve(mem_br_resolve), .mem_br_taken(mem_br_taken), .mem_is_trap(mem_is_trap),
    .fetch_en(fetch_en), .load_pc(load_pc), .pc_mux_sel(pc_mux_sel), .load_de(load_de),
    .load_ex(load_ex), .load_mem(load_mem), .load_wb(load_wb), .valid_de(valid_de),
    .valid_ex(valid_ex), .valid_mem(valid_mem), .valid_wb(valid_wb), .br_wait(br_wait)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_retired(perf_retired), .perf_mstall(perf_mstall), .perf_brwait(perf_brwait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [12:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  vec_n  = 0;

  // Apply one cycle of inputs {rst_n,ic,dreq,dresp,dep,ctrl,res,taken,trap}
  // and queue the expected outputs
  // {fetch_en,load_pc,sel[1:0],ld_de,ld_ex,ld_mem,ld_wb,v_de,v_ex,v_mem,v_wb,br_wait}.
  task automatic step(input logic [8:0] in, input logic [12:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    {rst_n, icache_resp, dcache_req, dcache_resp, dep_stall, de_is_ctrl,
     mem_br_resolve, mem_br_taken, mem_is_trap} = in;
    e.idx = vec_n;
    e.exp = exp;
    sb_q.push_back(e);
    vec_n++;
  endtask

  // Monitor: every cycle the DUT presents its control word; compare against the queue head.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_t e;
      logic [12:0] act;
      e = sb_q.pop_front();
      act = {fetch_en, load_pc, pc_mux_sel, load_de, load_ex, load_mem, load_wb,
             valid_de, valid_ex, valid_mem, valid_wb, br_wait};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL vec%0d: got %b required %b", e.idx, act, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    {rst_n, icache_resp, dcache_req, dcache_resp, dep_stall, de_is_ctrl,
     mem_br_resolve, mem_br_taken, mem_is_trap} = '0;
    @(posedge clk);
    // Reset held, then streaming fetch with no hazards.
    step(9'b0_0_00_0_0_000, 13'b0_0_00_0000_0000_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_0000_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_1000_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_1100_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_1110_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_1111_0);
    // Dependency stall for two cycles.
    step(9'b1_1_00_1_0_000, 13'b1_0_00_0111_1111_0);
    step(9'b1_1_00_1_0_000, 13'b1_0_00_0111_1011_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_1001_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_1100_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_1110_0);
    // Dcache miss for five cycles, dep_stall overlapping (mstall dominates).
    step(9'b1_1_10_0_0_000, 13'b1_0_00_0001_1111_0);
    step(9'b1_1_10_1_0_000, 13'b1_0_00_0001_1110_0);
    step(9'b1_1_10_1_0_000, 13'b1_0_00_0001_1110_0);
    step(9'b1_1_10_0_0_000, 13'b1_0_00_0001_1110_0);
    step(9'b1_1_10_0_0_000, 13'b1_0_00_0001_1110_0);
    step(9'b1_1_11_0_0_000, 13'b1_1_00_1111_1110_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_1111_0);
    // Taken branch: freeze, BR_WAIT, redirect to target, three DE bubbles.
    step(9'b1_1_00_0_1_000, 13'b0_0_00_1111_1111_0);
    step(9'b1_0_00_0_0_000, 13'b0_0_00_1111_0111_1);
    step(9'b1_0_00_0_0_110, 13'b0_1_01_1111_0011_1);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_0001_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_1000_0);
    // Not-taken branch: no PC load on resolve.
    step(9'b1_1_00_0_1_000, 13'b0_0_00_1111_1100_0);
    step(9'b1_0_00_0_0_000, 13'b0_0_00_1111_0110_1);
    step(9'b1_0_00_0_0_100, 13'b0_0_00_1111_0011_1);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_0001_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_1000_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_1100_0);
    // Resolve asserted while in RUN with valid MEM is ignored.
    step(9'b1_1_00_0_0_111, 13'b1_1_00_1111_1110_0);
    // TRAP whose resolve coincides with a dcache miss: redirect waits for dcache_resp.
    step(9'b1_1_00_0_1_000, 13'b0_0_00_1111_1111_0);
    step(9'b1_0_00_0_0_000, 13'b0_0_00_1111_0111_1);
    step(9'b1_0_10_0_0_101, 13'b0_0_00_0001_0011_1);
    step(9'b1_0_10_0_0_101, 13'b0_0_00_0001_0010_1);
    step(9'b1_0_11_0_0_101, 13'b0_1_10_1111_0010_1);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_0001_0);
    // Branch in DE with dep_stall: held in DE, stays RUN, fetch frozen.
    step(9'b1_1_00_1_1_000, 13'b0_0_00_0111_1000_0);
    step(9'b1_1_00_0_1_000, 13'b0_0_00_1111_1000_0);
    // Resolve with valid_mem=0 in BR_WAIT is ignored.
    step(9'b1_0_00_0_0_110, 13'b0_0_00_1111_0100_1);
    // Reset in the middle of BR_WAIT.
    step(9'b0_0_00_0_0_000, 13'b0_0_00_0000_0010_0);
    step(9'b1_0_00_0_0_000, 13'b1_0_00_1111_0000_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_0000_0);
    step(9'b1_1_00_0_0_000, 13'b1_1_00_1111_1000_0);
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central sequencer for the 5-stage LC-3b pipeline (fetch, decode, execute, mem, write-back). It owns the stage valid bits and generates per-latch load enables, the fetch enable and the PC select. It resolves three hazard sources: icache miss, dcache miss and decode RAW dependency. Control-flow instructions are handled by a no-prediction freeze-until-resolve policy, with resolution in the MEM stage.

Parameters:
PERF_W, 16, width of the performance counters. Only used when PIPE_CTRL_PERF_EN is defined.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
icache_resp  in  1  fetch word valid this cycle
dcache_req  in  1  instruction in MEM needs a dcache read/write
dcache_resp  in  1  dcache access complete
dep_stall  in  1  decode detects a RAW hazard on its source registers
de_is_ctrl  in  1  DE holds BR/JMP/JSR/TRAP
mem_br_resolve  in  1  MEM holds a control instruction with a final outcome
mem_br_taken  in  1  the control instruction redirects to ex_mem address
mem_is_trap  in  1  the control instruction is TRAP; target is the trap vector
fetch_en  out  1  icache_read request
load_pc  out  1  PC register load
pc_mux_sel  out  2  00 pc+2, 01 branch target, 10 trap pc
load_de  out  1  fetch/decode latch load
load_ex  out  1  decode/execute latch load
load_mem  out  1  execute/mem latch load
load_wb  out  1  mem/wb latch load
valid_de  out  1  DE stage holds a real instruction (registered)
valid_ex  out  1  EX stage holds a real instruction (registered)
valid_mem  out  1  MEM stage holds a real instruction (registered)
valid_wb  out  1  WB stage holds a real instruction (registered)
br_wait  out  1  state == BR_WAIT (debug/visibility)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - all valid_* = 0; state = RUN; counters = 0.
  - While rst_n=0, all combinational outputs are forced to 0.
- Definitions:
  - mstall = valid_mem & dcache_req & ~dcache_resp
  - ctrl_de = valid_de & de_is_ctrl
  - resolve = valid_mem & mem_br_resolve & ~mstall
- States:
  - RUN: normal fetch.
  - BR_WAIT: fetch frozen until the outstanding control instruction resolves.
- Load enables (combinational):
  - load_wb = 1.
  - load_mem = load_ex = ~mstall.
  - load_de = ~mstall & ~dep_stall.
- Valid propagation:
  - When a latch does not load, its valid bit holds.
  - valid_wb <= valid_mem & ~mstall.
  - valid_mem <= valid_ex when load_mem.
  - valid_ex <= valid_de & ~dep_stall when load_ex. A dependency stall inserts an EX bubble.
  - valid_de <= (state==RUN) & ~ctrl_de & icache_resp when load_de. A miss or a branch freeze inserts a DE bubble.
- Fetch:
  - fetch_en = (state==RUN) & ~ctrl_de.
  - In RUN: load_pc = load_de & icache_resp & ~ctrl_de, with pc_mux_sel = 00.
  - The word fetched alongside a control instruction in DE is discarded and the PC is not advanced. The PC already holds the fall-through address.
- RUN -> BR_WAIT: when ctrl_de & load_de (control instruction advances to EX).
- BR_WAIT behaviour:
  - fetch_en = 0.
  - DE bubbles inserted each cycle.
  - mstall holds state.
- BR_WAIT -> RUN on resolve:
  - mem_is_trap: load_pc = 1, pc_mux_sel = 10.
  - else mem_br_taken: load_pc = 1, pc_mux_sel = 01.
  - else (not taken): load_pc = 0, because the PC already holds the fall-through.
  - Fetch resumes the next cycle.
- Boundary conditions:
  - mem_br_resolve with valid_mem=0, or in RUN, is ignored.
  - dep_stall with ctrl_de: the branch holds in DE, the state stays RUN and fetch stays frozen.
  - mstall and dep_stall together: mstall dominates. All latches except WB hold; WB gets a bubble.
  - icache_resp=0 in RUN: PC holds; DE gets a bubble only if load_de.
  - Reset mid-BR_WAIT: return to RUN with all stages invalid.
- Default: pc_mux_sel = 00 whenever load_pc is driven by RUN logic.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - Adds outputs perf_retired, perf_mstall and perf_brwait, each PERF_W wide.
  - perf_retired counts cycles with valid_wb.
  - perf_mstall counts mstall cycles.
  - perf_brwait counts BR_WAIT cycles.
  - All counters saturate at all-ones and clear on reset.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then icache_resp=1 continuously, no hazards:
   - valid_de=1 on the 1st cycle after reset release; valid_wb=1 on the 4th.
   - load_pc=1 every cycle.
2. ADD in DE with dep_stall=1 for 2 cycles:
   - load_de=0 for 2 cycles; valid_ex=0 for 2 cycles.
   - PC holds; the instruction proceeds on the 3rd cycle.
3. Load in MEM with dcache_req=1 and dcache_resp delayed 5 cycles:
   - load_ex=load_mem=0 for 5 cycles; valid_wb=0 during the stall.
   - valid_wb=1 the cycle after dcache_resp.
4. Taken BR:
   - ctrl_de=1 -> fetch_en=0, then BR_WAIT.
   - resolve with mem_br_taken=1 -> load_pc=1, pc_mux_sel=01.
   - Exactly 3 DE bubbles; RUN restored.
5. Not-taken BR and TRAP:
   - Not-taken resolve -> load_pc=0, pc_mux_sel=00, RUN.
   - TRAP resolve -> pc_mux_sel=10.
   - With mstall on the resolve cycle, the redirect is delayed until dcache_resp.
6. rst_n=0 during BR_WAIT:
   - Next cycle: all valid_*=0, br_wait=0, counters=0 (when PIPE_CTRL_PERF_EN is defined).
